// File: rtl/vid_count9_pkg.sv
// Shared types for the vid_count9 timing-chain counter.
package vid_count9_pkg;
  typedef logic [8:0] count9_t;
  localparam count9_t COUNT9_MAX = 9'h1FF;
  typedef enum logic {WIN_IDLE = 1'b0, WIN_ACTIVE = 1'b1} win_state_t;
endpackage

// File: rtl/count9_eq.sv
// 9-bit equality compare; purely combinational, registering is left to the caller.
module count9_eq
  import vid_count9_pkg::*;
(
  input  count9_t a,
  input  count9_t b,
  output logic    eq
);
  assign eq = (a == b);
endmodule

// File: rtl/vid_count9.sv
// 9-bit programmable event counter with registered terminal/match strobes and a window level.
// Optional sticky interrupt on terminal count when VID_COUNT9_IRQ_EN is defined.
module vid_count9
  import vid_count9_pkg::*;
#(
  parameter int      COUNT_W     = 9,
  parameter count9_t RESET_VALUE = 9'h000
) (
  input  logic               MasterClock,
  input  logic               ResetN,
  input  logic               Enable,
  input  logic               Load,
  input  logic [COUNT_W-1:0] LoadValue,
  input  logic [COUNT_W-1:0] TermCount,
  input  logic [COUNT_W-1:0] MatchA,
  input  logic [COUNT_W-1:0] MatchB,
`ifdef VID_COUNT9_IRQ_EN
  input  logic               IrqAck,
  output logic               IrqReq,
`endif
  output logic [COUNT_W-1:0] Count,
  output logic               Term,
  output logic               MatchAPulse,
  output logic               MatchBPulse,
  output logic               Window
);

  count9_t    r_count;
  logic       r_term, r_match_a, r_match_b;
  win_state_t r_state, w_state_nxt;
  logic       w_t_ev, w_a_ev, w_b_ev, w_tick;
  count9_t    w_count_inc;

  count9_eq u_eq_term (.a(r_count), .b(TermCount), .eq(w_t_ev));
  count9_eq u_eq_a    (.a(r_count), .b(MatchA),    .eq(w_a_ev));
  count9_eq u_eq_b    (.a(r_count), .b(MatchB),    .eq(w_b_ev));

  assign w_tick      = Enable & ~Load;
  assign w_count_inc = (r_count == COUNT9_MAX) ? '0 : r_count + 9'd1;

  always_ff @(posedge MasterClock or negedge ResetN) begin
    if (!ResetN) begin
      r_count   <= RESET_VALUE;
      r_term    <= 1'b0;
      r_match_a <= 1'b0;
      r_match_b <= 1'b0;
    end else begin
      r_term    <= w_tick & w_t_ev;
      r_match_a <= w_tick & w_a_ev;
      r_match_b <= w_tick & w_b_ev;
      if (Load)
        r_count <= LoadValue;
      else if (Enable)
        r_count <= w_t_ev ? '0 : w_count_inc;
    end
  end

  always_ff @(posedge MasterClock or negedge ResetN) begin
    if (!ResetN)
      r_state <= WIN_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Close events (B or terminal) take precedence over an open on the same tick.
  always_comb begin
    w_state_nxt = r_state;
    if (Load) begin
      w_state_nxt = WIN_IDLE;
    end else if (Enable) begin
      case (r_state)
        WIN_IDLE:   if (w_a_ev && !w_b_ev && !w_t_ev) w_state_nxt = WIN_ACTIVE;
        WIN_ACTIVE: if (w_b_ev || w_t_ev)             w_state_nxt = WIN_IDLE;
        default:    w_state_nxt = WIN_IDLE;
      endcase
    end
  end

`ifdef VID_COUNT9_IRQ_EN
  logic r_irq;
  always_ff @(posedge MasterClock or negedge ResetN) begin
    if (!ResetN)
      r_irq <= 1'b0;
    else if (w_tick && w_t_ev)
      r_irq <= 1'b1;
    else if (IrqAck)
      r_irq <= 1'b0;
  end
  assign IrqReq = r_irq;
`endif

  assign Count       = r_count;
  assign Term        = r_term;
  assign MatchAPulse = r_match_a;
  assign MatchBPulse = r_match_b;
  assign Window      = (r_state == WIN_ACTIVE);

endmodule

// File: tb/tb_vid_count9.sv
// Scoreboard bench for vid_count9: driver queues hand-computed expectations, monitor compares after each edge.
module tb_vid_count9;

`ifdef VID_COUNT9_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  logic       MasterClock = 1'b0;
  logic       ResetN = 1'b1;
  logic       Enable = 1'b0;
  logic       Load = 1'b0;
  logic [8:0] LoadValue = '0;
  logic [8:0] TermCount = 9'd5;
  logic [8:0] MatchA = 9'd100;
  logic [8:0] MatchB = 9'd100;
  logic       ack = 1'b0;
  logic [8:0] Count;
  logic       Term, MatchAPulse, MatchBPulse, Window;
  logic       irq_o;

  vid_count9 dut (
    .MasterClock(MasterClock), .ResetN(ResetN), .Enable(Enable), .Load(Load),
    .LoadValue(LoadValue), .TermCount(TermCount), .MatchA(MatchA), .MatchB(MatchB),
`ifdef VID_COUNT9_IRQ_EN
    .IrqAck(ack), .IrqReq(irq_o),
`endif
    .Count(Count), .Term(Term), .MatchAPulse(MatchAPulse), .MatchBPulse(MatchBPulse),
    .Window(Window)
  );

`ifndef VID_COUNT9_IRQ_EN
  assign irq_o = 1'b0;
`endif

  always #5 MasterClock = ~MasterClock;

  typedef struct packed {
    logic [15:0] id;
    logic [8:0]  c;
    logic        t, a, b, w, ci, i;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   vid = 0;

  task automatic check_now(input string name, input logic [8:0] c, input logic t,
                           input logic a, input logic b, input logic w);
    checks++;
    if (Count !== c || Term !== t || MatchAPulse !== a || MatchBPulse !== b || Window !== w) begin
      errors++;
      $display("FAIL %s got cnt=%h T=%b A=%b B=%b W=%b want cnt=%h T=%b A=%b B=%b W=%b",
               name, Count, Term, MatchAPulse, MatchBPulse, Window, c, t, a, b, w);
    end
  endtask

  // Drive one edge's inputs at a negedge and queue what the outputs must show after that edge.
  task automatic step(input logic en, input logic ld, input logic [8:0] lv, input logic ak,
                      input logic [8:0] c, input logic t, input logic a, input logic b,
                      input logic w, input logic ci, input logic i);
    exp_t e;
    Enable = en; Load = ld; LoadValue = lv; ack = ak;
    e.id = vid[15:0]; e.c = c; e.t = t; e.a = a; e.b = b; e.w = w; e.ci = ci; e.i = i;
    vid++;
    q.push_back(e);
    @(negedge MasterClock);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge MasterClock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (Count !== e.c || Term !== e.t || MatchAPulse !== e.a || MatchBPulse !== e.b ||
            Window !== e.w || (e.ci && irq_o !== e.i)) begin
          errors++;
          $display("FAIL vec%0d got cnt=%h T=%b A=%b B=%b W=%b irq=%b want cnt=%h T=%b A=%b B=%b W=%b irq=%b",
                   e.id, Count, Term, MatchAPulse, MatchBPulse, Window, irq_o,
                   e.c, e.t, e.a, e.b, e.w, e.i);
        end
      end
    end
  end

  initial begin : driver
    #1 ResetN = 1'b0; Enable = 1'b1;
    #2 check_now("reset_async", 9'd0, 0, 0, 0, 0);
    @(posedge MasterClock); #2;
    check_now("reset_hold_enable", 9'd0, 0, 0, 0, 0);
    @(negedge MasterClock);
    ResetN = 1'b1;

    // Run to TermCount=5 and wrap
    TermCount = 9'd5; MatchA = 9'd100; MatchB = 9'd100;
    for (int k = 1; k <= 5; k++) step(1, 0, 0, 0, k[8:0], 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 9'd0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 9'd1, 0, 0, 0, 0, 0, 0);

    // Window A=2 B=6 Term=9
    TermCount = 9'd9; MatchA = 9'd2; MatchB = 9'd6;
    step(0, 1, 9'd0, 0, 9'd0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 9'd1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 9'd2, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 9'd3, 0, 1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 9'd4, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 9'd5, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 9'd6, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 9'd7, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 9'd8, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 9'd9, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 9'd0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 9'd1, 0, 0, 0, 0, 0, 0);

    // Terminal count closes an open window
    TermCount = 9'd5; MatchA = 9'd2; MatchB = 9'd100;
    step(0, 1, 9'd0, 0, 9'd0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 9'd1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 9'd2, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 9'd3, 0, 1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 9'd4, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 9'd5, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 9'd0, 1, 0, 0, 0, 0, 0);

    // MatchA == MatchB: both pulse, window stays closed
    TermCount = 9'd9; MatchA = 9'd4; MatchB = 9'd4;
    step(0, 1, 9'd0, 0, 9'd0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) step(1, 0, 0, 0, k[8:0], 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 9'd5, 0, 1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 9'd6, 0, 0, 0, 0, 0, 0);

    // MatchA == TermCount: Term and A pulse, window stays closed
    TermCount = 9'd9; MatchA = 9'd9; MatchB = 9'd100;
    step(0, 1, 9'd7, 0, 9'd7, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 9'd8, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 9'd9, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 9'd0, 1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 9'd1, 0, 0, 0, 0, 0, 0);

    // Load beats Enable, suppresses pulses, closes window; 1FF wraps without Term
    TermCount = 9'h010; MatchA = 9'd2; MatchB = 9'd100;
    step(0, 1, 9'd0, 0, 9'd0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 9'd1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 9'd2, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 9'd3, 0, 1, 0, 1, 0, 0);
    MatchA = 9'd3;
    step(1, 1, 9'h1FE, 0, 9'h1FE, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 9'h1FF, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 9'h000, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 9'h001, 0, 0, 0, 0, 0, 0);

    // Enable gaps
    TermCount = 9'd9; MatchA = 9'd100; MatchB = 9'd100;
    step(0, 1, 9'd0, 0, 9'd0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 9'd1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 9'd1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 9'd1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 9'd2, 0, 0, 0, 0, 0, 0);
    TermCount = 9'd2;
    step(1, 0, 0, 0, 9'd0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 9'd0, 0, 0, 0, 0, 0, 0);

    // Async reset in the middle of an open window
    TermCount = 9'd20; MatchA = 9'd1; MatchB = 9'd100;
    step(0, 1, 9'd0, 0, 9'd0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 9'd1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 9'd2, 0, 1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 9'd3, 0, 0, 0, 1, 0, 0);
    #1 ResetN = 1'b0;
    #1 check_now("reset_mid_window", 9'd0, 0, 0, 0, 0);
    @(negedge MasterClock);
    ResetN = 1'b1;

    // Interrupt: set with Term, set wins over ack, lone ack clears, Load keeps it
    TermCount = 9'd2; MatchA = 9'd100; MatchB = 9'd100;
    step(1, 0, 0, 0, 9'd1, 0, 0, 0, 0, IRQ_BUILD, 0);
    step(1, 0, 0, 0, 9'd2, 0, 0, 0, 0, IRQ_BUILD, 0);
    step(1, 0, 0, 0, 9'd0, 1, 0, 0, 0, IRQ_BUILD, 1);
    step(1, 0, 0, 0, 9'd1, 0, 0, 0, 0, IRQ_BUILD, 1);
    step(1, 0, 0, 0, 9'd2, 0, 0, 0, 0, IRQ_BUILD, 1);
    step(1, 0, 0, 1, 9'd0, 1, 0, 0, 0, IRQ_BUILD, 1);
    step(0, 0, 0, 1, 9'd0, 0, 0, 0, 0, IRQ_BUILD, 0);
    step(0, 0, 0, 0, 9'd0, 0, 0, 0, 0, IRQ_BUILD, 0);
    step(1, 0, 0, 0, 9'd1, 0, 0, 0, 0, IRQ_BUILD, 0);
    step(1, 0, 0, 0, 9'd2, 0, 0, 0, 0, IRQ_BUILD, 0);
    step(1, 0, 0, 0, 9'd0, 1, 0, 0, 0, IRQ_BUILD, 1);
    step(0, 1, 9'd5, 0, 9'd5, 0, 0, 0, 0, IRQ_BUILD, 1);

    Enable = 1'b0; Load = 1'b0; ack = 1'b0;
    for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge MasterClock);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
